prio_arbiter4: RTL and testbench

Four-requester fixed-priority arbiter with grant lock and hold-time preemption. It shares one downstream resource between requesters 0..3, with requester 3 highest and requester 0 lowest. It registers a one-hot grant plus its binary index, using the same index encoding as the team's 4:2 priority encoder. It sits between requesting blocks and the shared datapath they sequence onto.

---
 rtl/prio_arb_pkg.sv | 12 +
 rtl/prio_enc4.sv | 26 ++
 rtl/prio_arbiter4.sv | 105 ++++++++++
 tb/tb_prio_arbiter4.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/prio_arb_pkg.sv
// Shared types and sizes for the four-requester fixed-priority arbiter.
package prio_arb_pkg;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

endpackage

// File: rtl/prio_enc4.sv
// Masked 4:2 priority encoder; requester 3 wins, masked-off lines never win.
module prio_enc4
    import prio_arb_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] mask,
    output logic            valid,
    output logic [IDW-1:0]  idx
);

    logic [NREQ-1:0] masked;

    assign masked = req & ~mask;
    assign valid  = |masked;

    always_comb begin
        idx = '0;
        casez (masked)
            4'b1???: idx = 2'd3;
            4'b01??: idx = 2'd2;
            4'b001?: idx = 2'd1;
            default: idx = 2'd0;
        endcase
    end

endmodule

// File: rtl/prio_arbiter4.sv
// Fixed-priority arbiter with grant lock and hold-time preemption.
// A holder keeps the grant until it drops req or has held MAX_HOLD cycles under contention.
module prio_arbiter4
    import prio_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id,
    output logic            busy
);

    localparam int             CW      = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0]  MAX_CNT = CW'(MAX_HOLD);
    localparam logic [NREQ-1:0] ONE    = {{(NREQ-1){1'b0}}, 1'b1};

    state_e          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [CW-1:0]   hold_cnt_q, hold_cnt_d;

    logic [NREQ-1:0] enc_mask;
    logic            enc_valid;
    logic [IDW-1:0]  enc_idx;
    logic            holder_req;
    logic            timeout;

    assign holder_req = |(req & gnt_q);
    assign timeout    = (MAX_HOLD != 0) && (hold_cnt_q == MAX_CNT);

    // Only a timed-out holder that still requests is excluded from the next pick.
    assign enc_mask = ((state_q == GRANT) && holder_req && timeout) ? gnt_q : '0;

    prio_enc4 u_enc (
        .req   (req),
        .mask  (enc_mask),
        .valid (enc_valid),
        .idx   (enc_idx)
    );

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        id_d       = id_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            IDLE: begin
                if (enc_valid) begin
                    state_d    = GRANT;
                    gnt_d      = ONE << enc_idx;
                    id_d       = enc_idx;
                    hold_cnt_d = CW'(1);
                end
            end
            GRANT: begin
                if (!holder_req) begin
                    if (enc_valid) begin
                        gnt_d      = ONE << enc_idx;
                        id_d       = enc_idx;
                        hold_cnt_d = CW'(1);
                    end else begin
                        state_d    = IDLE;
                        gnt_d      = '0;
                        id_d       = '0;
                        hold_cnt_d = '0;
                    end
                end else if (timeout && enc_valid) begin
                    gnt_d      = ONE << enc_idx;
                    id_d       = enc_idx;
                    hold_cnt_d = CW'(1);
                end else if ((MAX_HOLD != 0) && (hold_cnt_q != MAX_CNT)) begin
                    hold_cnt_d = hold_cnt_q + CW'(1);
                end
            end
            default: begin
                state_d    = IDLE;
                gnt_d      = '0;
                id_d       = '0;
                hold_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            id_q       <= '0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            id_q       <= id_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign gnt    = gnt_q;
    assign gnt_id = id_q;
    assign busy   = (state_q == GRANT);

endmodule

// File: tb/tb_prio_arbiter4.sv
// Drives three arbiters (MAX_HOLD = 0, 4, 8) with shared stimulus and checks them against a holder/count model.
module tb_prio_arbiter4;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gntW   [3];
    logic [1:0] gntIdW [3];
    logic       busyW  [3];

    int holder  [3];
    int holdCnt [3];
    int maxHold [3];
    int compared;
    int mismatched;

    prio_arbiter4 #(.MAX_HOLD(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(gntW[0]), .gnt_id(gntIdW[0]), .busy(busyW[0])
    );
    prio_arbiter4 #(.MAX_HOLD(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(gntW[1]), .gnt_id(gntIdW[1]), .busy(busyW[1])
    );
    prio_arbiter4 #(.MAX_HOLD(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(gntW[2]), .gnt_id(gntIdW[2]), .busy(busyW[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Highest set bit of a request vector, -1 if none.
    function automatic int highest(input logic [3:0] r);
        for (int i = 3; i >= 0; i--) begin
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < 3; k++) begin
            holder[k]  = -1;
            holdCnt[k] = 0;
        end
    endtask

    // One clock edge of arbitration rules, applied to each parameterisation.
    task automatic modelStep(input logic [3:0] r);
        int h;
        int others;
        for (int k = 0; k < 3; k++) begin
            h = holder[k];
            if (h < 0) begin
                if (r != 0) begin
                    holder[k]  = highest(r);
                    holdCnt[k] = 1;
                end
            end else if (!r[h]) begin
                holder[k]  = highest(r);
                holdCnt[k] = (r != 0) ? 1 : 0;
            end else begin
                others = highest(r & ~(4'b0001 << h));
                if (maxHold[k] != 0 && holdCnt[k] == maxHold[k] && others >= 0) begin
                    holder[k]  = others;
                    holdCnt[k] = 1;
                end else if (maxHold[k] == 0) begin
                    holdCnt[k] = 1;
                end else if (holdCnt[k] < maxHold[k]) begin
                    holdCnt[k] = holdCnt[k] + 1;
                end
            end
        end
    endtask

    task automatic compareAll();
        logic [3:0] expGnt;
        logic [1:0] expId;
        logic       expBusy;
        for (int k = 0; k < 3; k++) begin
            expGnt  = (holder[k] < 0) ? 4'b0000 : (4'b0001 << holder[k]);
            expId   = (holder[k] < 0) ? 2'd0 : 2'(holder[k]);
            expBusy = (holder[k] >= 0);
            checkOutput($sformatf("gnt[mh=%0d]", maxHold[k]), 32'(gntW[k]), 32'(expGnt));
            checkOutput($sformatf("gnt_id[mh=%0d]", maxHold[k]), 32'(gntIdW[k]), 32'(expId));
            checkOutput($sformatf("busy[mh=%0d]", maxHold[k]), 32'(busyW[k]), 32'(expBusy));
        end
    endtask

    task automatic applyStimulus(input logic [3:0] r);
        @(negedge clk);
        req = r;
        @(posedge clk);
        modelStep(r);
        #1;
        compareAll();
    endtask

    // Asserts reset between edges, checks the immediate clear, then releases with a new request.
    task automatic doReset(input logic [3:0] releaseReq);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        modelReset();
        #1;
        compareAll();
        @(negedge clk);
        rst_n = 1'b1;
        req   = releaseReq;
        @(posedge clk);
        modelStep(releaseReq);
        #1;
        compareAll();
    endtask

    initial begin
        logic [3:0] r;
        compared   = 0;
        mismatched = 0;
        maxHold[0] = 0;
        maxHold[1] = 4;
        maxHold[2] = 8;
        modelReset();
        req   = 4'b0000;
        rst_n = 1'b0;
        #3;
        compareAll();
        @(negedge clk);
        rst_n = 1'b1;

        // Reset in the middle of a grant to requester 3.
        applyStimulus(4'b1000);
        applyStimulus(4'b1000);
        doReset(4'b0010);
        applyStimulus(4'b0000);

        // Priority from idle and lock while the holder keeps requesting.
        applyStimulus(4'b0111);
        for (int i = 0; i < 10; i++) applyStimulus(4'b0111);
        applyStimulus(4'b0000);

        // Back-to-back handoff from holder 3 to holder 0.
        applyStimulus(4'b1001);
        applyStimulus(4'b0001);
        applyStimulus(4'b0001);
        applyStimulus(4'b0000);

        // Lock: a higher request cannot take over from holder 0 until it releases.
        applyStimulus(4'b0001);
        applyStimulus(4'b1001);
        applyStimulus(4'b1001);
        applyStimulus(4'b1000);
        applyStimulus(4'b1000);
        applyStimulus(4'b0000);

        // Constant contention exercises the timeout handoffs.
        for (int i = 0; i < 24; i++) applyStimulus(4'b1001);
        applyStimulus(4'b0000);

        // Saturated counter, then a newcomer takes over immediately.
        for (int i = 0; i < 20; i++) applyStimulus(4'b0010);
        applyStimulus(4'b0110);
        applyStimulus(4'b0110);
        applyStimulus(4'b0000);

        // Random traffic with requests that tend to persist.
        r = 4'b0000;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(3, 0) == 0) r = 4'($urandom_range(15, 0));
            if (i == 400) doReset(r);
            else applyStimulus(r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
